mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer that shares the single memory port between the instruction-fetch requester and the data (load/store) requester of the ARM pipeline. It accepts held request/done handshakes from both sides and arbitrates with data priority plus a starvation guard for fetch. It drives the memory's enable/rw/size/address controls for the duration of each access, captures read data, and reports completion, misalignment or timeout back to the winning requester.

## Interface
- ADDR_W, 9: byte address width.
- FAIR, 4: consecutive data grants allowed while fetch is pending before fetch is forced.
- TIMEOUT, 15: max cycles an access waits for mem_ready before error completion.

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address (always word)
- if_done  out  1  one-cycle completion pulse to fetch
- if_err  out  1  valid with if_done: access failed
- if_rdata  out  32  fetched word, valid with if_done
- d_req  in  1  data request, held until d_done
- d_rw  in  1  0 read (LDRB), 1 write (STR), same encoding as control unit mem_rw
- d_size  in  1  1 word, 0 byte, same encoding as control unit mem_size
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  store data
- d_done  out  1  one-cycle completion pulse to data side
- d_err  out  1  valid with d_done
- d_rdata  out  32  load data, valid with d_done
- mem_enable  out  1  memory access active
- mem_rw  out  1  memory direction
- mem_size  out  1  memory access size
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- mem_ready  in  1  memory completes access this cycle

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: arbitrate on sampled requests.
  - d_req only → data.
  - if_req only → fetch.
  - Both → data, unless starve_cnt == FAIR, then fetch.
  - Winner's addr/rw/size/wdata are latched. Fetch is latched as rw=0, size=1.
- Misalignment check at grant: a word access with addr[1:0] != 0 goes to RESP with err=1. No memory cycle is issued.
- starve_cnt increments on each data grant made while if_req=1. It clears on a fetch grant, or in any IDLE cycle with if_req=0. It saturates at FAIR.
- BUSY_x: mem_enable=1 and mem_* are driven from the latches, stable for the whole access. wait_cnt increments each cycle.
  - mem_ready=1: capture mem_rdata and go to RESP with err=0.
  - wait_cnt == TIMEOUT with mem_ready=0: go to RESP with err=1 and rdata=0.
- RESP: pulse the owner's x_done=1 for one cycle with x_err and x_rdata valid, then return to IDLE.
- Read formatting: size=0 returns {24'b0, mem_rdata[7:0]}; size=1 returns the word. Writes return rdata=0.
- Byte writes drive mem_wdata = {24'b0, d_wdata[7:0]}.
- A requester dropping req mid-access does not abort: the access completes and done still pulses.
- Requests are not re-sampled until IDLE. A requester must not raise a new request in the cycle its done pulses.

## Timing
- Reset values: state=IDLE; all *_done, *_err, mem_enable, mem_rw, mem_size = 0; mem_addr, mem_wdata, *_rdata = 0; starve_cnt = wait_cnt = 0.
- Reset wins over every other event, including mid-access. Any in-flight access is dropped with no done pulse.
- Latency, for a request seen in IDLE at cycle 0:
  - mem_enable is high from cycle 1.
  - If mem_ready is high at cycle k (k≥1), done pulses at cycle k+1.
  - Minimum is 2 cycles to done, so at most one access per 3 cycles.
- Misaligned access: done with err=1 at cycle 1, with no mem_enable.
- Timeout: mem_enable high for cycles 1..TIMEOUT; done with err=1 at cycle TIMEOUT+1.
- mem_enable is low in IDLE and RESP. Outputs of the non-owner requester stay 0.

## Test plan
- Fetch only, if_addr=0x010, mem_ready at cycle 1, mem_rdata=0xE3A01005 → mem_enable cycle 1 only; if_done=1, if_rdata=0xE3A01005, if_err=0 at cycle 2.
- Simultaneous if_req and d_req (LDRB at 0x023, mem_rdata=0x11223344) → data first, d_rdata=0x00000044; fetch granted in the following IDLE.
- Data held continuously with if_req pending, FAIR=4 → four data grants, then a fetch grant, then data resumes.
- STR word at 0x022 → d_done with d_err=1 one cycle after grant, and mem_enable never asserted.
- mem_ready held low → mem_enable high 15 cycles, then d_done with d_err=1 and d_rdata=0; a subsequent fetch completes normally.
- Reset asserted during BUSY_D → next cycle all outputs 0 and state IDLE, with no d_done pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store. Data has
// priority; a starvation counter forces a fetch grant after FAIR data wins.
module mem_port_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int FAIR    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic              if_err,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic              d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic              mem_enable,
  output logic              mem_rw,
  output logic              mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int SW = $clog2(FAIR + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] FAIR_C = SW'(FAIR);
  localparam logic [WW-1:0] TO_C   = WW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic              owner_q, owner_d;   // 1 = data side owns the access
  logic              rw_q, rw_d;
  logic              size_q, size_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              grant;
  logic              busy, resp;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    wait_d   = wait_q;
    owner_d  = owner_q;
    rw_d     = rw_q;
    size_d   = size_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    grant    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!if_req) starve_d = '0;
        if (d_req && !(if_req && starve_q == FAIR_C)) begin
          grant   = 1'b1;
          owner_d = 1'b1;
          rw_d    = d_rw;
          size_d  = d_size;
          addr_d  = d_addr;
          wdata_d = !d_rw ? 32'd0 : (d_size ? d_wdata : {24'd0, d_wdata[7:0]});
          if (if_req && starve_q != FAIR_C) starve_d = starve_q + 1'b1;
        end else if (if_req) begin
          grant    = 1'b1;
          owner_d  = 1'b0;
          rw_d     = 1'b0;
          size_d   = 1'b1;
          addr_d   = if_addr;
          wdata_d  = '0;
          starve_d = '0;
        end
        if (grant) begin
          wait_d  = WW'(1);
          rdata_d = '0;
          // Misaligned word accesses complete with error and never touch memory.
          if (size_d && addr_d[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = owner_d ? BUSY_D : BUSY_I;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        wait_d = wait_q + 1'b1;
        if (mem_ready) begin
          rdata_d = rw_q ? 32'd0 : (size_q ? mem_rdata : {24'd0, mem_rdata[7:0]});
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wait_q == TO_C) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        wait_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      wait_q   <= '0;
      owner_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wait_q   <= wait_d;
      owner_q  <= owner_d;
      err_q    <= err_d;
    end
  end

  // Access latches carry no reset; every output they feed is gated by state.
  always_ff @(posedge clk) begin
    rw_q    <= rw_d;
    size_q  <= size_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  assign busy       = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign resp       = (state_q == RESP);
  assign mem_enable = busy;
  assign mem_rw     = busy & rw_q;
  assign mem_size   = busy & size_q;
  assign mem_addr   = busy ? addr_q : '0;
  assign mem_wdata  = busy ? wdata_q : '0;

  assign if_done  = resp & ~owner_q;
  assign if_err   = if_done & err_q;
  assign if_rdata = if_done ? rdata_q : '0;
  assign d_done   = resp & owner_q;
  assign d_err    = d_done & err_q;
  assign d_rdata  = d_done ? rdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level model of arbitration and completion.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 9;
  localparam int FAIR    = 4;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req, d_req, d_rw, d_size, mem_ready;
  logic [ADDR_W-1:0] if_addr, d_addr, mem_addr;
  logic [31:0]       d_wdata, mem_rdata, mem_wdata, if_rdata, d_rdata;
  logic              if_done, if_err, d_done, d_err;
  logic              mem_enable, mem_rw, mem_size;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          starve_m = 0;
  logic        last_win, last_err;
  logic [31:0] last_rdata;
  logic [31:0] tmp;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .FAIR(FAIR), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {27'd0, mem_enable, mem_rw, mem_size, if_done, d_done}, 32'd0);
    check({tag, "_err"}, {30'd0, if_err, d_err}, 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_if_rdata"}, if_rdata, 32'd0);
    check({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  // Called in an IDLE cycle with requests already driven; runs one access to done.
  task automatic run_txn(input int lat, input logic [31:0] rd);
    logic              win_d, e_rw, e_size, e_err, mis;
    logic [ADDR_W-1:0] e_addr;
    logic [31:0]       e_wdata, e_rdata;
    int                done_at;
    win_d = d_req && !(if_req && starve_m >= FAIR);
    if (win_d && if_req) starve_m = (starve_m < FAIR) ? starve_m + 1 : FAIR;
    else starve_m = 0;
    e_rw    = win_d ? d_rw : 1'b0;
    e_size  = win_d ? d_size : 1'b1;
    e_addr  = win_d ? d_addr : if_addr;
    e_wdata = e_size ? d_wdata : (d_wdata & 32'hFF);
    mis     = e_size && (int'(e_addr) % 4 != 0);
    if (mis) begin
      done_at = 1; e_err = 1'b1; e_rdata = 32'd0;
    end else if (lat <= TIMEOUT) begin
      done_at = lat + 1; e_err = 1'b0;
      e_rdata = e_rw ? 32'd0 : (e_size ? rd : (rd & 32'hFF));
    end else begin
      done_at = TIMEOUT + 1; e_err = 1'b1; e_rdata = 32'd0;
    end
    for (int t = 1; t <= done_at; t++) begin
      @(posedge clk); #1;
      if (t < done_at) begin
        check("busy_en", 32'(mem_enable), 32'd1);
        check("busy_addr", 32'(mem_addr), 32'(e_addr));
        check("busy_rw_size", {30'd0, mem_rw, mem_size}, {30'd0, e_rw, e_size});
        if (e_rw) check("busy_wdata", mem_wdata, e_wdata);
        check("busy_dones", {30'd0, if_done, d_done}, 32'd0);
        mem_ready = (t == lat);
        mem_rdata = (t == lat) ? rd : $urandom;
      end else begin
        mem_ready  = 1'b0;
        last_win   = win_d;
        last_err   = win_d ? d_err : if_err;
        last_rdata = win_d ? d_rdata : if_rdata;
        check("resp_en", 32'(mem_enable), 32'd0);
        check("resp_done", {30'd0, if_done, d_done}, win_d ? 32'd1 : 32'd2);
        check("resp_err", 32'(last_err), 32'(e_err));
        check("resp_rdata", last_rdata, e_rdata);
        check("loser_err", 32'(win_d ? if_err : d_err), 32'd0);
        check("loser_rdata", win_d ? if_rdata : d_rdata, 32'd0);
        if (win_d) d_req = 1'b0;
        else if_req = 1'b0;
      end
    end
    @(posedge clk); #1;
    check("post_idle", {29'd0, mem_enable, if_done, d_done}, 32'd0);
  endtask

  task automatic idle_cycle();
    starve_m = 0;
    @(posedge clk); #1;
    check("idle", {29'd0, mem_enable, if_done, d_done}, 32'd0);
  endtask

  task automatic set_data(input logic rw, input logic sz, input logic [ADDR_W-1:0] a,
                          input logic [31:0] wd);
    d_req = 1'b1; d_rw = rw; d_size = sz; d_addr = a; d_wdata = wd;
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_rw = 1'b0; d_size = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    starve_m = 0;

    // Fetch only
    if_req = 1'b1; if_addr = 9'h010;
    run_txn(1, 32'hE3A01005);
    check("fetch_win", 32'(last_win), 32'd0);
    check("fetch_rdata", last_rdata, 32'hE3A01005);

    // Simultaneous: LDRB wins, fetch follows
    if_req = 1'b1; if_addr = 9'h020;
    set_data(1'b0, 1'b0, 9'h023, 32'hDEADBEEF);
    run_txn(2, 32'h11223344);
    check("both_win", 32'(last_win), 32'd1);
    check("ldrb_rdata", last_rdata, 32'h00000044);
    run_txn(1, 32'hA5A5_0F0F);
    check("both_next_fetch", 32'(last_win), 32'd0);

    // Fairness: four data grants, one fetch, then data again
    if_req = 1'b1; if_addr = 9'h100;
    for (int i = 0; i < 6; i++) begin
      set_data(1'b1, 1'b1, ADDR_W'(9'h040 + 4 * i), $urandom);
      run_txn(1, $urandom);
      check("fair_win", 32'(last_win), (i == 4) ? 32'd0 : 32'd1);
      if (i == 4) d_req = 1'b0;
    end

    // Misaligned STR word
    set_data(1'b1, 1'b1, 9'h022, 32'h12345678);
    run_txn(1, 32'd0);
    check("mis_err", 32'(last_err), 32'd1);

    // Timeout, then normal fetch
    set_data(1'b0, 1'b1, 9'h030, 32'd0);
    run_txn(TIMEOUT + 5, 32'hFFFF_FFFF);
    check("to_err", 32'(last_err), 32'd1);
    check("to_rdata", last_rdata, 32'd0);
    if_req = 1'b1; if_addr = 9'h014;
    run_txn(3, 32'hCAFE_F00D);
    check("after_to_err", 32'(last_err), 32'd0);
    check("after_to_rdata", last_rdata, 32'hCAFE_F00D);

    // Reset during BUSY_D drops the access without a done pulse
    set_data(1'b0, 1'b1, 9'h050, 32'd0);
    @(posedge clk); #1;
    check("rst_busy_en", 32'(mem_enable), 32'd1);
    reset = 1'b1; d_req = 1'b0;
    @(posedge clk); #1;
    check_zero("rst_mid");
    reset = 1'b0; starve_m = 0;
    @(posedge clk); #1;
    check_zero("rst_after");
    if_req = 1'b1; if_addr = 9'h018;
    run_txn(1, 32'h0BAD_CAFE);
    check("rst_fetch_rdata", last_rdata, 32'h0BAD_CAFE);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      int lat;
      if (!if_req && $urandom_range(0, 1) == 1) begin
        tmp = $urandom; if_addr = tmp[ADDR_W-1:0]; if_addr[1:0] = 2'b00; if_req = 1'b1;
      end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        tmp = $urandom;
        if ($urandom_range(0, 3) != 0) tmp[1:0] = 2'b00;
        set_data(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tmp[ADDR_W-1:0], $urandom);
      end
      lat = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 3)
                                        : $urandom_range(1, 4);
      if (!if_req && !d_req) idle_cycle();
      else run_txn(lat, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
